// File: rtl/tmod_sampler_pkg.sv
// Shared types for the temperature-module sampler: command opcodes, status codes
// and the command FSM encoding.
package tmod_sampler_pkg;

    typedef enum logic [1:0] {
        RESET   = 2'b00,
        SET_FRQ = 2'b01,
        NOOP    = 2'b10,
        RSVD    = 2'b11
    } tmod_state_e;

    typedef enum logic [1:0] {
        STAT_IDLE     = 2'b00,
        STAT_BUSY     = 2'b01,
        STAT_OVERFLOW = 2'b10
    } tmod_status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } samp_fsm_e;

    // Opcodes that restart the sampling interval when they execute.
    function automatic logic clearsTimer(input tmod_state_e op);
        return (op == RESET) || (op == SET_FRQ);
    endfunction

endpackage

// File: rtl/tmod_sampler_rate_timer.sv
// Sample-rate timer: a PRESCALE-cycle prescaler feeding an interval counter that
// fires sample_tick once every freq_div prescaler ticks.
module tmod_rate_timer
    import tmod_sampler_pkg::*;
#(
    parameter int PRESCALE = 1000,
    parameter int FW       = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic [FW-1:0] freq_div,
    output logic          sample_tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;
    logic [FW-1:0] r_int;
    logic          w_enabled;
    logic          w_preTick;
    logic          w_intLast;

    assign w_enabled   = (freq_div != '0);
    assign w_preTick   = w_enabled && (r_pre == PRE_LAST);
    assign w_intLast   = (r_int == (freq_div - 1'b1));
    assign sample_tick = w_preTick && w_intLast;

    // A zero divider parks both counters so no events are produced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
            r_int <= '0;
        end else if (clear || !w_enabled) begin
            r_pre <= '0;
            r_int <= '0;
        end else begin
            r_pre <= w_preTick ? '0 : r_pre + 1'b1;
            if (w_preTick) begin
                r_int <= w_intLast ? '0 : r_int + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmod_sampler.sv
// Temperature-module sampler: executes master commands through a 3-cycle FSM and
// streams periodic sensor samples out on a valid/ready interface.
module tmod_sampler
    import tmod_sampler_pkg::*;
#(
    parameter int DW       = 8,
    parameter int PRESCALE = 1000,
    parameter int FW       = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [FW-1:0] cmd_data,
    output logic          cmd_done,
    input  logic [DW-1:0] sensor_temp,
    output logic          samp_valid,
    output logic [DW-1:0] samp_data,
    input  logic          samp_ready,
    output logic          overflow,
    output logic [FW-1:0] freq_div
);

    samp_fsm_e     r_state;
    samp_fsm_e     w_nextState;
    tmod_state_e   r_op;
    logic [FW-1:0] r_data;
    logic [FW-1:0] r_freqDiv;
    logic [DW-1:0] r_sampData;
    logic          r_sampValid;
    logic          r_overflow;

    logic          w_cmdReady;
    logic          w_cmdDone;
    logic          w_exec;
    logic          w_timerClear;
    logic          w_sampleTick;
    logic          w_event;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_cmdReady  = 1'b0;
        w_cmdDone   = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmdReady = 1'b1;
                if (cmd_valid) begin
                    w_nextState = S_EXEC;
                end
            end
            S_EXEC: begin
                w_exec      = 1'b1;
                w_nextState = S_DONE;
            end
            S_DONE: begin
                w_cmdDone   = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op   <= NOOP;
            r_data <= '0;
        end else if (cmd_valid && w_cmdReady) begin
            r_op   <= tmod_state_e'(cmd_op);
            r_data <= cmd_data;
        end
    end

    // A command that restarts the timer also swallows any event landing on the same edge.
    assign w_timerClear = w_exec && clearsTimer(r_op);
    assign w_event      = w_sampleTick && !w_timerClear;

    tmod_rate_timer #(
        .PRESCALE (PRESCALE),
        .FW       (FW)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (w_timerClear),
        .freq_div    (r_freqDiv),
        .sample_tick (w_sampleTick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_freqDiv   <= '0;
            r_sampValid <= 1'b0;
            r_sampData  <= '0;
            r_overflow  <= 1'b0;
        end else if (w_exec && (r_op == RESET)) begin
            r_freqDiv   <= '0;
            r_sampValid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_exec && (r_op == SET_FRQ)) begin
                r_freqDiv <= r_data;
            end
            if (w_event) begin
                if (!r_sampValid || samp_ready) begin
                    r_sampData  <= sensor_temp;
                    r_sampValid <= 1'b1;
                end else begin
                    r_overflow  <= 1'b1;
                end
            end else if (r_sampValid && samp_ready) begin
                r_sampValid <= 1'b0;
            end
        end
    end

    assign cmd_ready  = w_cmdReady;
    assign cmd_done   = w_cmdDone;
    assign samp_valid = r_sampValid;
    assign samp_data  = r_sampData;
    assign overflow   = r_overflow;
    assign freq_div   = r_freqDiv;

endmodule

// File: tb/tb_tmod_sampler.sv
// Self-checking bench for tmod_sampler: scenario tasks compare the DUT against an
// edge-counting reference model of command timing and periodic sampling.
module tb_tmod_sampler;
    import tmod_sampler_pkg::*;

    localparam int PRESCALE = 4;
    localparam int DW       = 8;
    localparam int FW       = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [FW-1:0] cmd_data;
    logic          cmd_done;
    logic [DW-1:0] sensor_temp;
    logic          samp_valid;
    logic [DW-1:0] samp_data;
    logic          samp_ready;
    logic          overflow;
    logic [FW-1:0] freq_div;

    int errors = 0;
    int checks = 0;
    bit rampMode;

    tmod_sampler #(
        .DW       (DW),
        .PRESCALE (PRESCALE),
        .FW       (FW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_done    (cmd_done),
        .sensor_temp (sensor_temp),
        .samp_valid  (samp_valid),
        .samp_data   (samp_data),
        .samp_ready  (samp_ready),
        .overflow    (overflow),
        .freq_div    (freq_div)
    );

    always #5 clk = ~clk;

    // Reference model: edges are numbered from reset, a command accepted at edge A
    // takes effect at A+1, and samples fire every freq_div*PRESCALE edges after that.
    int         mEdge;
    int         mAcc;
    int         mAnchor;
    int         mFd;
    bit         mValid;
    bit         mOvf;
    logic [7:0] mData;
    logic [1:0] mOp;
    logic [7:0] mArg;

    task automatic modelStep();
        bit ev;
        bit rdyBefore;
        bit wiped;
        if (!reset_n) begin
            mEdge   = 0;
            mAcc    = -10;
            mAnchor = 0;
            mFd     = 0;
            mValid  = 1'b0;
            mOvf    = 1'b0;
            mData   = 8'h00;
            mOp     = 2'b10;
            mArg    = 8'h00;
        end else begin
            mEdge     = mEdge + 1;
            rdyBefore = !(((mEdge - 1 - mAcc) == 0) || ((mEdge - 1 - mAcc) == 1));
            ev        = (mFd != 0) && (mEdge > mAnchor) &&
                        (((mEdge - mAnchor) % (mFd * PRESCALE)) == 0);
            wiped     = 1'b0;
            if (mEdge == mAcc + 1) begin
                if (mOp == 2'b00) begin
                    mFd = 0; mValid = 1'b0; mOvf = 1'b0; mAnchor = mEdge; ev = 1'b0; wiped = 1'b1;
                end else if (mOp == 2'b01) begin
                    mFd = int'(mArg); mAnchor = mEdge; ev = 1'b0;
                end
            end
            if (!wiped) begin
                if (ev) begin
                    if (!mValid || samp_ready) begin
                        mData  = sensor_temp;
                        mValid = 1'b1;
                    end else begin
                        mOvf = 1'b1;
                    end
                end else if (mValid && samp_ready) begin
                    mValid = 1'b0;
                end
            end
            if (rdyBefore && cmd_valid) begin
                mAcc = mEdge;
                mOp  = cmd_op;
                mArg = cmd_data;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            modelStep();
        end
    end

    wire [19:0] dutVec = {cmd_ready, cmd_done, samp_valid, samp_data, overflow, freq_div};
    wire [19:0] expVec = {!(((mEdge - mAcc) == 0) || ((mEdge - mAcc) == 1)),
                          ((mEdge - mAcc) == 1), mValid, mData, mOvf, 8'(mFd)};

    task automatic cycle();
        @(negedge clk);
        if (rampMode) sensor_temp = sensor_temp + 1'b1;
        else          sensor_temp = 8'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b10; cmd_data = '0;
        samp_ready = 1'b0; sensor_temp = '0; rampMode = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if (dutVec !== 20'h80000) begin
            errors++; $display("[TB] FAIL reset_values got=%h exp=%h", dutVec, 20'h80000);
        end
        cycle();
        cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            checks++;
            if (dutVec !== expVec) begin
                errors++; $display("[TB] FAIL idle_vec i=%0d got=%h exp=%h", i, dutVec, expVec);
            end
        end
        checks++;
        if ({cmd_ready, samp_valid, overflow, freq_div} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("[TB] FAIL idle_state got=%b_%b_%b_%h exp=1_0_0_00",
                               cmd_ready, samp_valid, overflow, freq_div);
        end
    endtask

    task automatic test_set_frq3();
        int validCount;
        logic [7:0] expD;
        validCount  = 0;
        rampMode    = 1'b1;
        samp_ready  = 1'b1;
        sensor_temp = 8'h10;
        cmd_valid = 1'b1; cmd_op = SET_FRQ; cmd_data = 8'd3;
        cycle();
        checks++;
        if (dutVec !== expVec) begin
            errors++; $display("[TB] FAIL frq3_accept got=%h exp=%h", dutVec, expVec);
        end
        cmd_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            checks++;
            if (dutVec !== expVec) begin
                errors++; $display("[TB] FAIL frq3_vec k=%0d got=%h exp=%h", k, dutVec, expVec);
            end
            if (samp_valid) validCount++;
            if (k == 0) begin
                checks++;
                if (cmd_done !== 1'b1) begin
                    errors++; $display("[TB] FAIL frq3_done_pulse got=%b exp=1", cmd_done);
                end
            end
            if (k == 1) begin
                checks++;
                if (cmd_done !== 1'b0) begin
                    errors++; $display("[TB] FAIL frq3_done_single got=%b exp=0", cmd_done);
                end
            end
            if (k > 0 && (k % 12) == 0) begin
                expD = 8'(8'h11 + k);
                checks++;
                if ({samp_valid, samp_data} !== {1'b1, expD}) begin
                    errors++; $display("[TB] FAIL frq3_ramp k=%0d got=%b/%h exp=1/%h",
                                       k, samp_valid, samp_data, expD);
                end
            end
        end
        checks++;
        if (validCount !== 3 || freq_div !== 8'd3) begin
            errors++; $display("[TB] FAIL frq3_count got=%0d/%0d exp=3/3", validCount, freq_div);
        end
        rampMode = 1'b0;
    endtask

    task automatic test_set_frq2_overflow();
        logic [7:0] saved;
        saved = '0;
        samp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = SET_FRQ; cmd_data = 8'd2;
        cycle();
        cmd_valid = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            cycle();
            checks++;
            if (dutVec !== expVec) begin
                errors++; $display("[TB] FAIL frq2_vec k=%0d got=%h exp=%h", k, dutVec, expVec);
            end
            if (k == 7) saved = sensor_temp;
            if (k == 8 || k == 15) begin
                checks++;
                if ({samp_valid, samp_data, overflow} !== {1'b1, saved, 1'b0}) begin
                    errors++; $display("[TB] FAIL frq2_first k=%0d got=%b/%h/%b exp=1/%h/0",
                                       k, samp_valid, samp_data, overflow, saved);
                end
            end
            if (k == 16) begin
                checks++;
                if ({samp_valid, samp_data, overflow} !== {1'b1, saved, 1'b1}) begin
                    errors++; $display("[TB] FAIL frq2_drop got=%b/%h/%b exp=1/%h/1",
                                       samp_valid, samp_data, overflow, saved);
                end
            end
            if (k == 17) samp_ready = 1'b1;
            if (k == 18) begin
                checks++;
                if ({samp_valid, overflow} !== 2'b01) begin
                    errors++; $display("[TB] FAIL frq2_drain got=%b%b exp=01", samp_valid, overflow);
                end
            end
        end
    endtask

    task automatic test_noop_reset();
        int validCount;
        validCount = 0;
        cmd_valid = 1'b1; cmd_op = NOOP; cmd_data = 8'($urandom);
        cycle();
        cmd_valid = 1'b0;
        cycle();
        checks++;
        if ({cmd_done, overflow, freq_div} !== {1'b1, 1'b1, 8'd2}) begin
            errors++; $display("[TB] FAIL noop_done got=%b/%b/%h exp=1/1/02", cmd_done, overflow, freq_div);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (dutVec !== expVec) begin
                errors++; $display("[TB] FAIL noop_vec i=%0d got=%h exp=%h", i, dutVec, expVec);
            end
        end
        cmd_valid = 1'b1; cmd_op = RESET; cmd_data = 8'($urandom);
        cycle();
        cmd_valid = 1'b0;
        cycle();
        checks++;
        if ({cmd_done, overflow, samp_valid, freq_div} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("[TB] FAIL rstop_clear got=%b/%b/%b/%h exp=1/0/0/00",
                               cmd_done, overflow, samp_valid, freq_div);
        end
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (samp_valid) validCount++;
            checks++;
            if (dutVec !== expVec) begin
                errors++; $display("[TB] FAIL rstop_vec i=%0d got=%h exp=%h", i, dutVec, expVec);
            end
        end
        checks++;
        if (validCount !== 0) begin
            errors++; $display("[TB] FAIL rstop_nosample got=%0d exp=0", validCount);
        end
    endtask

    task automatic test_back_to_back();
        int doneCount;
        int lowCount;
        int sel;
        doneCount = 0;
        lowCount  = 0;
        sel       = $urandom_range(0, 2);
        cmd_op    = (sel == 0) ? NOOP : ((sel == 1) ? RSVD : SET_FRQ);
        cmd_data  = 8'($urandom_range(0, 3));
        cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks++;
            if (dutVec !== expVec) begin
                errors++; $display("[TB] FAIL b2b_vec i=%0d got=%h exp=%h", i, dutVec, expVec);
            end
            if (cmd_done) doneCount++;
            if (!cmd_ready) lowCount++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (doneCount !== 4 || lowCount !== 8) begin
            errors++; $display("[TB] FAIL b2b_rate got=%0d/%0d exp=4/8", doneCount, lowCount);
        end
        for (int i = 0; i < 4; i++) cycle();
    endtask

    task automatic test_async_reset();
        int validCount;
        validCount = 0;
        samp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = SET_FRQ; cmd_data = 8'd5;
        cycle();
        cmd_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, cmd_done, samp_valid, overflow, freq_div} !== {4'b1000, 8'h00}) begin
            errors++; $display("[TB] FAIL async_rst got=%b%b%b%b/%h exp=1000/00",
                               cmd_ready, cmd_done, samp_valid, overflow, freq_div);
        end
        checks++;
        if (dutVec !== expVec) begin
            errors++; $display("[TB] FAIL async_rst_vec got=%h exp=%h", dutVec, expVec);
        end
        cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (samp_valid) validCount++;
            checks++;
            if (dutVec !== expVec) begin
                errors++; $display("[TB] FAIL async_vec i=%0d got=%h exp=%h", i, dutVec, expVec);
            end
        end
        checks++;
        if (validCount !== 0 || freq_div !== 8'h00) begin
            errors++; $display("[TB] FAIL async_nosample got=%0d/%h exp=0/00", validCount, freq_div);
        end
    endtask

    task automatic test_random();
        bit pending;
        int r;
        pending = 1'b0;
        for (int i = 0; i < 800; i++) begin
            cycle();
            checks++;
            if (dutVec !== expVec) begin
                errors++; $display("[TB] FAIL rand_vec i=%0d got=%h exp=%h", i, dutVec, expVec);
            end
            samp_ready = 1'($urandom_range(0, 1));
            if (pending && mAcc == mEdge) begin
                pending   = 1'b0;
                cmd_valid = 1'b0;
            end else if (!pending && $urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 9);
                cmd_op    = (r == 0) ? RESET : ((r <= 4) ? SET_FRQ : ((r <= 8) ? NOOP : RSVD));
                cmd_data  = 8'($urandom_range(0, 3));
                cmd_valid = 1'b1;
                pending   = 1'b1;
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_set_frq3();
        test_set_frq2_overflow();
        test_noop_reset();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
